// File: rtl/clock_divider_pkg.sv
// Shared constants and elaboration helpers for the synchronous clock divider.
// Board rates are expressed as divisors of the system clock.
package clock_divider_pkg;

  // Display scan rate and count rate of the 7-segment demo board.
  localparam int SCAN_DIV       = 1000;
  localparam int COUNT_RATE_DIV = 50000;

  // True when div is a legal non-zero divisor that fits in width bits.
  function automatic bit div_fits(int div, int width);
    return (div >= 1) && ($clog2(div + 1) <= width);
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: divisor register, down-counter, tick pulse and square wave.
// A load restarts the period immediately and suppresses any coincident tick.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = SCAN_DIV
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_step,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_div,
  output logic             o_tick,
  output logic             o_clk
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(DEFAULT_DIV - 1);

  logic [WIDTH-1:0] div_reg, div_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] eff_div;
  logic             tick_reg, tick_next;
  logic             clk_reg, clk_next;

  // A stored divisor of zero behaves as divide-by-one.
  assign eff_div = (div_reg == '0) ? WIDTH'(1) : div_reg;

  always_comb begin
    div_next  = div_reg;
    cnt_next  = cnt_reg;
    tick_next = 1'b0;
    clk_next  = clk_reg;
    if (i_load) begin
      div_next = i_div;
      cnt_next = (i_div == '0) ? '0 : i_div - WIDTH'(1);
    end else if (i_step) begin
      if (cnt_reg == '0) begin
        cnt_next  = eff_div - WIDTH'(1);
        tick_next = 1'b1;
        clk_next  = ~clk_reg;
      end else begin
        cnt_next = cnt_reg - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_reg  <= RST_DIV;
      cnt_reg  <= RST_CNT;
      tick_reg <= 1'b0;
      clk_reg  <= 1'b0;
    end else begin
      div_reg  <= div_next;
      cnt_reg  <= cnt_next;
      tick_reg <= tick_next;
      clk_reg  <= clk_next;
    end
  end

  assign o_tick = tick_reg;
  assign o_clk  = clk_reg;

endmodule

// File: rtl/clock_divider_sync.sv
// Multi-channel synchronous clock divider producing clock-enable ticks and square waves.
// In cascade mode each later channel steps on the previous channel's registered tick.
module clock_divider_sync
  import clock_divider_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int N_CH        = 2,
  parameter int DEFAULT_DIV = SCAN_DIV,
  parameter int CASCADE     = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [N_CH-1:0]  i_load,
  input  logic [WIDTH-1:0] i_div,
  output logic [N_CH-1:0]  o_tick,
  output logic [N_CH-1:0]  o_clk
);

  if (!div_fits(DEFAULT_DIV, WIDTH)) begin : g_bad_default_div
    $error("clock_divider_sync: DEFAULT_DIV must be in 1 .. 2**WIDTH-1");
  end

  logic [N_CH-1:0] step;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    if ((CASCADE != 0) && (gi > 0)) begin : g_cascade
      assign step[gi] = i_en & o_tick[gi-1];
    end else begin : g_direct
      assign step[gi] = i_en;
    end

    clock_divider_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_channel (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_step  (step[gi]),
      .i_load  (i_load[gi]),
      .i_div   (i_div),
      .o_tick  (o_tick[gi]),
      .o_clk   (o_clk[gi])
    );
  end

endmodule

// File: tb/tb_clock_divider_sync.sv
// Self-checking bench: two divider instances (independent and cascaded) checked every
// cycle against a step-count model, plus literal expectations for the directed scenarios.
module tb_clock_divider_sync;

  localparam int W   = 8;
  localparam int NC  = 2;
  localparam int DEF = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          en    = 1'b0;
  logic [NC-1:0] load  = '0;
  logic [W-1:0]  div   = '0;

  logic [NC-1:0] tick_a, clk_a, tick_b, clk_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  clock_divider_sync #(.WIDTH(W), .N_CH(NC), .DEFAULT_DIV(DEF), .CASCADE(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_load(load), .i_div(div),
    .o_tick(tick_a), .o_clk(clk_a)
  );

  clock_divider_sync #(.WIDTH(W), .N_CH(NC), .DEFAULT_DIV(DEF), .CASCADE(1)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_load(load), .i_div(div),
    .o_tick(tick_b), .o_clk(clk_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: count steps since the last load/reset; a tick falls on every D-th step.
  int m_s  [2][NC];
  int m_d  [2][NC];
  bit m_tk [2][NC];
  bit m_ck [2][NC];

  function automatic bit stepped(int u, int c);
    if (c == 0 || u == 0) return en;
    return en && m_tk[u][c-1];
  endfunction

  function automatic bit hits(int u, int c);
    return ((m_s[u][c] + 1) % m_d[u][c]) == 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++)
        for (int c = 0; c < NC; c++) begin
          m_s[u][c]  <= 0;
          m_d[u][c]  <= DEF;
          m_tk[u][c] <= 1'b0;
          m_ck[u][c] <= 1'b0;
        end
    end else begin
      for (int u = 0; u < 2; u++)
        for (int c = 0; c < NC; c++) begin
          if (load[c]) begin
            m_s[u][c]  <= 0;
            m_d[u][c]  <= (div == '0) ? 1 : int'(div);
            m_tk[u][c] <= 1'b0;
          end else if (stepped(u, c)) begin
            m_s[u][c]  <= m_s[u][c] + 1;
            m_tk[u][c] <= hits(u, c);
            if (hits(u, c)) m_ck[u][c] <= ~m_ck[u][c];
          end else begin
            m_tk[u][c] <= 1'b0;
          end
        end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int u = 0; u < 2; u++)
        for (int c = 0; c < NC; c++) begin
          check($sformatf("model_tick_u%0d_c%0d", u, c),
                (u == 0) ? tick_a[c] : tick_b[c], m_tk[u][c]);
          check($sformatf("model_clk_u%0d_c%0d", u, c),
                (u == 0) ? clk_a[c] : clk_b[c], m_ck[u][c]);
        end
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Release reset with i_en high and pin the first three ticks of channel 0/1.
  task automatic run_reset_seq();
    rst_n = 1'b1;
    en    = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      cycle();
      check("t1_tick0", tick_a[0], (e % 4) == 0);
      check("t1_clk0",  clk_a[0],  (e / 4) % 2);
      check("t1_tick1", tick_a[1], (e % 4) == 0);
      $display("t1 edge %0d tick=%b clk=%b", e, tick_a[0], clk_a[0]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev;
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tick", tick_a, 0);
    check("reset_clk",  clk_a,  0);

    // Reset release cadence
    run_reset_seq();

    // Asynchronous reset mid-period while o_clk is high
    @(posedge clk);
    #1 check("pre_rst_clk0", clk_a[0], 1);
    #1 rst_n = 1'b0;
    #1 check("async_rst_clk0", clk_a[0], 0);
    check("async_rst_tick", tick_a, 0);
    $display("async reset: clk=%b tick=%b", clk_a[0], tick_a[0]);
    @(negedge clk);
    run_reset_seq();

    // Load 3 on channel 0; channel 1 keeps its cadence
    load = 2'b01;
    div  = 8'd3;
    cycle();
    load = '0;
    check("t2_load_tick0", tick_a[0], 0);
    check("t2_load_tick1", tick_a[1], 0);
    for (int k = 1; k <= 9; k++) begin
      cycle();
      check("t2_tick0", tick_a[0], (k % 3) == 0);
      check("t2_tick1", tick_a[1], ((13 + k) % 4) == 0);
      $display("t2 k=%0d tick0=%b tick1=%b", k, tick_a[0], tick_a[1]);
    end

    // Divisors 0 and 1 both divide by two
    for (int dv = 0; dv <= 1; dv++) begin
      load = 2'b01;
      div  = W'(dv);
      cycle();
      load = '0;
      check("t3_load_tick0", tick_a[0], 0);
      prev = clk_a[0];
      for (int k = 0; k < 4; k++) begin
        cycle();
        check("t3_tick0", tick_a[0], 1);
        check("t3_clk0",  clk_a[0], !prev);
        $display("t3 div=%0d tick=%b clk=%b", dv, tick_a[0], clk_a[0]);
        prev = clk_a[0];
      end
    end

    // D=5, freeze at cnt=2 for 7 cycles
    load = 2'b01;
    div  = 8'd5;
    cycle();
    load = '0;
    repeat (2) begin
      cycle();
      check("t4_pre_tick0", tick_a[0], 0);
    end
    en   = 1'b0;
    prev = clk_a[0];
    repeat (7) begin
      cycle();
      check("t4_hold_tick0", tick_a[0], 0);
      check("t4_hold_clk0",  clk_a[0], prev);
    end
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check("t4_resume_tick0", tick_a[0], k == 3);
      $display("t4 resume k=%0d tick=%b", k, tick_a[0]);
    end

    // Cascade: D0=4, D1=3
    en    = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    load  = 2'b10;
    div   = 8'd3;
    cycle();
    load = '0;
    en   = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      cycle();
      check("t5_tick0", tick_b[0], (e % 4) == 0);
      check("t5_tick1", tick_b[1], (e >= 13) && (((e - 13) % 12) == 0));
      $display("t5 edge %0d tick0=%b tick1=%b clk1=%b", e, tick_b[0], tick_b[1], clk_b[1]);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en   = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < NC; c++) load[c] = ($urandom_range(0, 39) == 0);
      div  = W'($urandom_range(0, 12));
      if ($urandom_range(0, 599) == 0) begin
        load = '0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("random reset at iteration %0d", i);
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
